// File: rtl/sample_averager_pkg.sv
// sample_averager_pkg: definitions shared by the sample_averager files.
//   state_t       - 2-bit FSM state encoding for the averager handshake
//   LOG2N_DEFAULT - default log2 of the averaging window length
package sample_averager_pkg;

    typedef enum logic [1:0] {
        S_IN_WAIT  = 2'd0,
        S_IN_ACK   = 2'd1,
        S_OUT_WAIT = 2'd2,
        S_OUT_ACK  = 2'd3
    } state_t;

    localparam int LOG2N_DEFAULT = 2;

endpackage : sample_averager_pkg

// File: rtl/sample_averager_if.sv
// sample_averager_if: groups the upstream sample handshake and the downstream
// result handshake of sample_averager.
//   data_in  [7:0] - sample from upstream, valid while dav_in_ = 0
//   dav_in_        - upstream data-valid, active low
//   rfd_in         - ready-for-data to upstream, active high
//   avg      [7:0] - window mean
//   peak     [7:0] - window maximum
//   dav_out_       - result-valid to downstream, active low
//   rfd_out        - downstream ready-for-data, active high
// Modports: slave = the averager, master = the partner driving its inputs.
interface sample_averager_if;

    logic [7:0] data_in;
    logic       dav_in_;
    logic       rfd_in;
    logic [7:0] avg;
    logic [7:0] peak;
    logic       dav_out_;
    logic       rfd_out;

    modport master (
        output data_in, dav_in_, rfd_out,
        input  rfd_in, avg, peak, dav_out_
    );

    modport slave (
        input  data_in, dav_in_, rfd_out,
        output rfd_in, avg, peak, dav_out_
    );

endinterface : sample_averager_if

// File: rtl/sample_averager_max_2.sv
// max_2: unsigned 8-bit maximum of two operands.
//   a, b [7:0] - operands
//   y    [7:0] - larger of a and b
// The choice is made from the borrow of a - b, the same way the minimum
// selector upstream picks its operand.
module max_2 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    logic [8:0] diff;
    logic       borrow;

    assign diff   = {1'b0, a} - {1'b0, b};
    assign borrow = diff[8];

    // When a < b, a - (a - b) wraps back to b; otherwise a is kept.
    assign y = a - (borrow ? diff[7:0] : 8'd0);

endmodule : max_2

// File: rtl/sample_averager.sv
// sample_averager: accumulates 2^LOG2N samples taken over a dav_/rfd
// handshake and presents the window mean and peak on a second dav_/rfd
// handshake. Upstream is held off while a result is pending.
//   clock - single clock, rising edge
//   reset - synchronous, active high
//   bus   - sample_averager_if.slave (sample in, result out)
//
// state      | meaning
// S_IN_WAIT  | rfd_in high, waiting for dav_in_ low to take a sample
// S_IN_ACK   | sample taken, waiting for dav_in_ to return high
// S_OUT_WAIT | result offered (dav_out_ low), waiting for rfd_out low
// S_OUT_ACK  | result taken, waiting for rfd_out high before next window
module sample_averager
    import sample_averager_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    sample_averager_if.slave  bus
);

    state_t             state;
    logic [7+LOG2N:0]   sum;
    logic [LOG2N-1:0]   count;
    logic [7:0]         max_r;
    logic [7:0]         max_next;
    logic               rfd_in_r;
    logic               dav_out_r;
    logic [7:0]         avg_r;
    logic [7:0]         peak_r;

    max_2 u_max_2 (
        .a (max_r),
        .b (bus.data_in),
        .y (max_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IN_WAIT;
            sum       <= '0;
            count     <= '0;
            max_r     <= '0;
            rfd_in_r  <= 1'b1;
            dav_out_r <= 1'b1;
            avg_r     <= '0;
            peak_r    <= '0;
        end else begin
            case (state)
                S_IN_WAIT: begin
                    if (!bus.dav_in_) begin
                        sum      <= sum + {{LOG2N{1'b0}}, bus.data_in};
                        max_r    <= max_next;
                        count    <= count + LOG2N'(1);
                        rfd_in_r <= 1'b0;
                        state    <= S_IN_ACK;
                    end
                end
                S_IN_ACK: begin
                    if (bus.dav_in_) begin
                        // count wraps to zero exactly when the window is full
                        if (count == '0) begin
                            avg_r     <= sum[7+LOG2N:LOG2N];
                            peak_r    <= max_r;
                            dav_out_r <= 1'b0;
                            state     <= S_OUT_WAIT;
                        end else begin
                            rfd_in_r  <= 1'b1;
                            state     <= S_IN_WAIT;
                        end
                    end
                end
                S_OUT_WAIT: begin
                    if (!bus.rfd_out) begin
                        dav_out_r <= 1'b1;
                        state     <= S_OUT_ACK;
                    end
                end
                S_OUT_ACK: begin
                    if (bus.rfd_out) begin
                        sum      <= '0;
                        max_r    <= '0;
                        rfd_in_r <= 1'b1;
                        state    <= S_IN_WAIT;
                    end
                end
                default: state <= S_IN_WAIT;
            endcase
        end
    end

    assign bus.rfd_in   = rfd_in_r;
    assign bus.dav_out_ = dav_out_r;
    assign bus.avg      = avg_r;
    assign bus.peak     = peak_r;

endmodule : sample_averager
